// File: rtl/mdu_sequencer.sv
// mdu_sequencer
// Multi-cycle sequencer for the RV32IM M-extension execute unit. One
// operation is accepted from EX, the pipeline is stalled while the block
// works, and the result is presented for a single cycle with done_o.
// Multiplies take one working cycle; divides run a restoring loop of XLEN
// steps on operand magnitudes, followed by a sign fix. Divide-by-zero and
// signed overflow finish without entering the loop.
//
// Ports
//   clk_i      : clock, all state updates on the rising edge
//   rst_i      : synchronous active-high reset (overrides flush_i/start_i)
//   start_i    : EX holds a valid M-extension op (sampled only in IDLE)
//   funct3_i   : operation select (mul/mulh/mulhsu/mulhu/div/divu/rem/remu)
//   rs1_val_i  : operand A (dividend / multiplicand)
//   rs2_val_i  : operand B (divisor / multiplier)
//   flush_i    : aborts any op in progress, no done_o produced
//   result_o   : registered result, valid while done_o is high, held otherwise
//   done_o     : one-cycle completion strobe
//   busy_o     : sequencer is not idle
//   stall_o    : combinational pipeline stall request
module mdu_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            busy_o,
  output logic            stall_o
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   LastStep = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] opA_q, opA_d;
  logic [XLEN-1:0] opB_q, opB_d;
  // Only funct3[1:0] is kept: bit 2 (mul vs div) is already encoded by the
  // state the sequencer moves into.
  logic [1:0]      opSel_q, opSel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] result_q, result_d;

  // Multiplier. Extending to 2*XLEN instead of XLEN+1 gives the same low
  // 2*XLEN product bits, so a plain truncating multiply is enough.
  // mulhu zero-extends A; mulhsu and mulhu zero-extend B.
  logic [2*XLEN-1:0] mulA, mulB, product;

  always_comb begin
    mulA    = (opSel_q == 2'b11) ? {{XLEN{1'b0}}, opA_q}
                                 : {{XLEN{opA_q[XLEN-1]}}, opA_q};
    mulB    = opSel_q[1] ? {{XLEN{1'b0}}, opB_q}
                         : {{XLEN{opB_q[XLEN-1]}}, opB_q};
    product = mulA * mulB;
  end

  // One restoring divide step on magnitudes. The quotient register starts
  // out holding |A| and fills with quotient bits from the right as the
  // dividend bits are shifted into the remainder. diff[XLEN] is the borrow.
  logic            divSigned;
  logic [XLEN-1:0] divMag;
  logic [XLEN:0]   shifted, diff;
  logic            geq;
  logic [XLEN-1:0] remStep, quoStep, remFinal, quoFinal;

  always_comb begin
    divSigned = ~opSel_q[0];
    divMag    = (divSigned & opB_q[XLEN-1]) ? -opB_q : opB_q;
    shifted   = {rem_q, quo_q[XLEN-1]};
    diff      = shifted - {1'b0, divMag};
    geq       = ~diff[XLEN];
    remStep   = geq ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quoStep   = {quo_q[XLEN-2:0], geq};
    quoFinal  = (divSigned & (opA_q[XLEN-1] ^ opB_q[XLEN-1])) ? -quoStep : quoStep;
    remFinal  = (divSigned & opA_q[XLEN-1]) ? -remStep : remStep;
  end

  // Decode of the incoming operands while IDLE, used to pick the special
  // divide paths and to preload |A| into the quotient register.
  logic            inSigned, inDivZero, inOverflow;
  logic [XLEN-1:0] inMagA;

  always_comb begin
    inSigned   = ~funct3_i[0];
    inDivZero  = (rs2_val_i == '0);
    inOverflow = inSigned & (rs1_val_i == MinNeg) & (rs2_val_i == '1);
    inMagA     = (inSigned & rs1_val_i[XLEN-1]) ? -rs1_val_i : rs1_val_i;
  end

  // Next-state logic. A flush abandons everything except the held result.
  always_comb begin
    state_d  = state_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    opSel_d  = opSel_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;

    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            opA_d   = rs1_val_i;
            opB_d   = rs2_val_i;
            opSel_d = funct3_i[1:0];
            cnt_d   = '0;
            if (!funct3_i[2]) begin
              state_d = MUL;
            end else if (inDivZero) begin
              result_d = funct3_i[1] ? rs1_val_i : '1;
              state_d  = DONE;
            end else if (inOverflow) begin
              result_d = funct3_i[1] ? '0 : MinNeg;
              state_d  = DONE;
            end else begin
              rem_d   = '0;
              quo_d   = inMagA;
              state_d = DIV;
            end
          end
        end
        MUL: begin
          result_d = (opSel_q == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
          state_d  = DONE;
        end
        DIV: begin
          rem_d = remStep;
          quo_d = quoStep;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastStep) begin
            result_d = opSel_q[1] ? remFinal : quoFinal;
            state_d  = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      opSel_q  <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      opSel_q  <= opSel_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
    end
  end

  // Stall covers the accepting IDLE cycle and every working cycle, and is
  // dropped during reset since nothing can be accepted then.
  always_comb begin
    result_o = result_q;
    done_o   = (state_q == DONE);
    busy_o   = (state_q != IDLE);
    stall_o  = ~rst_i & ((start_i & (state_q == IDLE) & ~flush_i) |
                         (state_q == MUL) | (state_q == DIV));
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer
// Directed self-checking bench for mdu_sequencer. Inputs change and outputs
// are sampled around the falling clock edge; every op is held on start_i
// until its done cycle, as the stalled pipeline would do.
module tb_mdu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic        stall;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  mdu_sequencer #(.XLEN(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .funct3_i  (funct3),
    .rs1_val_i (rs1),
    .rs2_val_i (rs2),
    .flush_i   (flush),
    .result_o  (result),
    .done_o    (done),
    .busy_o    (busy),
    .stall_o   (stall)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present an op in the current (C0) cycle; called just after a falling edge
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b);
    funct3 = f;
    rs1    = a;
    rs2    = b;
    start  = 1'b1;
    #1;
  endtask

  // Issue one op, wait (bounded) for done, check latency/result/stall, then
  // step into the following IDLE cycle with start dropped.
  task automatic runOp(input string tag, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input int expLat, input logic [31:0] expRes);
    int cyc;
    bit stallOk;
    applyStimulus(f, a, b);
    stallOk = (stall === 1'b1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      #1;
      if (done !== 1'b1 && stall !== 1'b1) stallOk = 1'b0;
    end while (done !== 1'b1 && cyc < 60);
    checkOutput({tag, "_latency"}, cyc, expLat);
    checkOutput({tag, "_result"}, result, expRes);
    checkOutput({tag, "_stallInDone"}, {31'd0, stall}, 32'd0);
    checkOutput({tag, "_stallWhileBusy"}, {31'd0, stallOk}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput({tag, "_idleBusy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_idleDone"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int doneCount;
    int cyc;

    rst    = 1'b1;
    start  = 1'b1;
    flush  = 1'b1;
    funct3 = F_MUL;
    rs1    = 32'h1234_5678;
    rs2    = 32'h0000_0003;

    // Reset held with start and flush asserted
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_result", result, 32'h0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_stall", {31'd0, stall}, 32'd0);
    start = 1'b0;
    flush = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("postRst_busy", {31'd0, busy}, 32'd0);

    // Multiplies: done in C2
    runOp("mul",    F_MUL,    32'h0000_0004, 32'hFFFF_FFFE, 2, 32'hFFFF_FFF8);
    runOp("mulh",   F_MULH,   32'h7FFF_FFFF, 32'hFFFF_FFFE, 2, 32'hFFFF_FFFF);
    runOp("mulhsu", F_MULHSU, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 2, 32'hFFFF_FFFF);
    runOp("mulhu",  F_MULHU,  32'h7FFF_FFFF, 32'h0000_0002, 2, 32'h0000_0000);

    // Normal divides: done in C33
    runOp("div",     F_DIV, 32'h7FFF_FFFF, 32'h0000_0002, 33, 32'h3FFF_FFFF);
    runOp("remNeg",  F_REM, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 33, 32'h0000_0001);
    runOp("divSmall",F_DIV, 32'hFFFF_FFFE, 32'h8000_0000, 33, 32'h0000_0000);

    // Signed overflow: done in C1
    runOp("divOvf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    runOp("remOvf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000);

    // Divide by zero: done in C1
    runOp("divZero",  F_DIV,  32'h7FFF_FFFF, 32'h0000_0000, 1, 32'hFFFF_FFFF);
    runOp("remuZero", F_REMU, 32'h7FFF_FFFF, 32'h0000_0000, 1, 32'h7FFF_FFFF);

    // Flush in C10 of a divide: idle in C11, no done, result kept
    applyStimulus(F_DIV, 32'h7FFF_FFFF, 32'h0000_0002);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("flush_busyC10", {31'd0, busy}, 32'd1);
    start = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flush_busyC11", {31'd0, busy}, 32'd0);
    checkOutput("flush_result", result, 32'h7FFF_FFFF);
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) doneCount++;
    end
    checkOutput("flush_noDone", doneCount, 32'd0);
    checkOutput("flush_resultLater", result, 32'h7FFF_FFFF);

    // Flush wins over start in IDLE
    applyStimulus(F_MUL, 32'h0000_0003, 32'h0000_0005);
    flush = 1'b1;
    #1;
    checkOutput("flushPrio_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    #1;
    checkOutput("flushPrio_busy", {31'd0, busy}, 32'd0);
    checkOutput("flushPrio_result", result, 32'h7FFF_FFFF);

    // Reset in the MUL cycle
    applyStimulus(F_MUL, 32'h0000_0004, 32'hFFFF_FFFE);
    @(negedge clk);
    #1;
    checkOutput("rstMul_busyC1", {31'd0, busy}, 32'd1);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstMul_result", result, 32'h0);
    checkOutput("rstMul_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstMul_done", {31'd0, done}, 32'd0);

    // Fresh unsigned divide after the abort
    runOp("divu", F_DIVU, 32'h7FFF_FFFF, 32'h0000_0002, 33, 32'h3FFF_FFFF);

    // Start held through DONE yields one done for the accepted op
    applyStimulus(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    doneCount = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      #1;
      if (done === 1'b1) doneCount++;
    end while (done !== 1'b1 && cyc < 10);
    checkOutput("hold_result", result, 32'hFFFF_FFFE);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) doneCount++;
    end
    checkOutput("hold_doneCount", doneCount, 32'd1);
    checkOutput("hold_busy", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
